// File: rtl/uart_tx_arbiter_if.sv
// Requester/FIFO-side bundle for uart_tx_arbiter: NREQ byte streams in, one TX FIFO write port out.
// master = requesters plus FIFO status (environment side), slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    ack;
  logic               fifo_full;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_wdata;

  modport master (
    output req, last, data, fifo_full,
    input  ack, fifo_wr, fifo_wdata
  );

  modport slave (
    input  req, last, data, fifo_full,
    output ack, fifo_wr, fifo_wdata
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART TX FIFO write port among NREQ byte streams.
// Optional stalled-grant revocation is compiled in with `define TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus,
  output logic [2:0]       grant_id,
  output logic             busy,
  output logic [NREQ-1:0]  abort
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("uart_tx_arbiter: MAX_BURST must be 1..255");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 2");
  end

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_rr_ptr;
  logic [2:0]         r_grant_id;
  logic [7:0]         r_cnt;

  logic [NREQ-1:0]    w_req;
  logic [NREQ-1:0]    w_last;
  logic [NREQ*DW-1:0] w_data;
  logic               w_full;
  logic [DW-1:0]      w_bytes [NREQ];

  logic [3:0]         w_idx;
  logic [2:0]         w_pick;
  logic               w_any;
  logic [IW-1:0]      w_gsel;
  logic               w_owner_req;
  logic               w_owner_last;

  logic               w_wr;
  logic [NREQ-1:0]    w_ack;
  logic [DW-1:0]      w_wdata;
  logic               w_release;
  logic               w_timeout;
  logic [NREQ-1:0]    w_abort;

  assign w_req  = bus.req;
  assign w_last = bus.last;
  assign w_data = bus.data;
  assign w_full = bus.fifo_full;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_bytes[i] = w_data[i*DW +: DW];
    end
  end

  // First requester strictly after r_rr_ptr, wrapping, so the last owner ranks lowest.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = 4'(r_rr_ptr) + 4'(k);
      if (w_idx >= 4'(NREQ)) begin
        w_idx = w_idx - 4'(NREQ);
      end
      if (!w_any && w_req[w_idx[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[2:0];
      end
    end
  end

  assign w_gsel       = r_grant_id[IW-1:0];
  assign w_owner_req  = w_req[w_gsel];
  assign w_owner_last = w_last[w_gsel];
  assign w_release    = w_wr & (w_owner_last | (r_cnt == 8'(MAX_BURST - 1)));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: only the owner can write, and only while the FIFO has room
  always_comb begin
    w_wr    = 1'b0;
    w_ack   = '0;
    w_wdata = '0;
    if (r_state == S_GRANT) begin
      w_wr = w_owner_req & ~w_full;
      if (w_wr) begin
        w_ack[w_gsel] = 1'b1;
        w_wdata       = w_bytes[w_gsel];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr   <= 3'(NREQ - 1);
      r_grant_id <= '0;
      r_cnt      <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_grant_id <= w_pick;
        r_cnt      <= '0;
      end
    end else if (w_release || w_timeout) begin
      r_rr_ptr <= r_grant_id;
      r_cnt    <= '0;
    end else if (w_wr) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [TW-1:0] r_tmo;
  logic          w_stall;

  // Only cycles where the owner withholds data count; a full FIFO is not the owner's fault.
  assign w_stall   = (r_state == S_GRANT) & ~w_owner_req & ~w_full;
  assign w_timeout = w_stall & (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if ((r_state != S_GRANT) || w_wr || w_timeout) begin
      r_tmo <= '0;
    end else if (w_stall) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_comb begin
    w_abort = '0;
    if (w_timeout) begin
      w_abort[w_gsel] = 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_abort   = '0;
`endif

  assign bus.fifo_wr    = w_wr;
  assign bus.fifo_wdata = w_wdata;
  assign bus.ack        = w_ack;
  assign grant_id       = r_grant_id;
  assign busy           = (r_state == S_GRANT);
  assign abort          = w_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level round-robin/burst model in the monitor.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  typedef struct packed {
    logic [15:0] cyc;
    logic [2:0]  own;
    logic [7:0]  d;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      grant_id;
  logic            busy;
  logic [NREQ-1:0] abort;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .DW(DW),
    .MAX_BURST(MAXB),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .grant_id(grant_id),
    .busy(busy),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned ncyc = 0;
  logic [8:0]  pend  [NREQ][$];
  logic [8:0]  exp_q [NREQ][$];
  wr_t         wr_log[$];
  logic [NREQ-1:0] hold = '0;
  logic [NREQ-1:0] ack_neg = '0;
  logic        full_force = 1'b0;
  int          full_pct = 0;
  int          n_abort = 0;
  int unsigned abort_cyc = 0;
  int          rst_epoch = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting index after the previous owner, wrapping.
  function automatic int rr_pick(input int lastp, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(lastp + k) % NREQ]) return (lastp + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_msg(input int r, input int len, input logic [7:0] d0, input bit randd);
    for (int k = 0; k < len; k++) begin
      logic [8:0] e;
      e[7:0] = randd ? 8'($urandom) : d0 + 8'(k);
      e[8]   = (k == len - 1);
      pend[r].push_back(e);
      exp_q[r].push_back(e);
    end
  endtask

  task automatic step();
    logic [NREQ-1:0]    r_v;
    logic [NREQ-1:0]    l_v;
    logic [NREQ*DW-1:0] d_v;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_neg[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    end
    r_v = '0;
    l_v = '0;
    d_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0 && !hold[i]) begin
        r_v[i]          = 1'b1;
        l_v[i]          = pend[i][0][8];
        d_v[i*DW +: DW] = pend[i][0][7:0];
      end
    end
    bus.req       = r_v;
    bus.last      = l_v;
    bus.data      = d_v;
    bus.fifo_full = full_force || (int'($urandom_range(99)) < full_pct);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_fifo_wr"}, bus.fifo_wr, 0);
    chk({tag, "_fifo_wdata"}, bus.fifo_wdata, 0);
    chk({tag, "_abort"}, abort, 0);
  endtask

  // Monitor: pops the scoreboard on every FIFO write and tracks grants at message level.
  int m_owner = 0;
  int m_last = NREQ - 1;
  int m_cnt = 0;
  int m_pick = 0;
  int seen_epoch = 0;
  bit m_pick_v = 1'b0;
  bit m_rel = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    ncyc++;
    ack_neg = bus.ack;
    if (seen_epoch != rst_epoch) begin
      seen_epoch = rst_epoch;
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
      m_last   = NREQ - 1;
      m_pick_v = 1'b0;
      m_rel    = 1'b0;
      m_cnt    = 0;
    end
    if (reset === 1'b1) begin
      if (m_pick_v) begin
        chk("grant_taken", busy, 1);
        chk("rr_pick", grant_id, m_pick);
        m_owner  = m_pick;
        m_cnt    = 0;
        m_pick_v = 1'b0;
      end else if (m_rel) begin
        chk("release", busy, 0);
        m_rel = 1'b0;
      end
      if (!busy) begin
        chk("idle_quiet", {bus.fifo_wr, bus.ack, bus.fifo_wdata}, 0);
        if (|bus.req) begin
          m_pick   = rr_pick(m_last, bus.req);
          m_pick_v = 1'b1;
        end
      end else begin
        chk("fifo_wr", bus.fifo_wr, bus.req[m_owner] & ~bus.fifo_full);
        if (bus.fifo_wr) begin
          chk("owner", grant_id, m_owner);
          chk("ack", bus.ack, 1 << m_owner);
          n_checks++;
          if (exp_q[m_owner].size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: write 0x%0h from %0d, expected no write", bus.fifo_wdata, m_owner);
          end else begin
            e = exp_q[m_owner].pop_front();
            if (bus.fifo_wdata !== e[7:0]) begin
              n_fail++;
              $display("FAIL wdata: got 0x%0h, expected 0x%0h (t=%0t)", bus.fifo_wdata, e[7:0], $time);
            end
            wr_log.push_back({16'(ncyc), grant_id, bus.fifo_wdata});
            m_cnt++;
            if (e[8] || m_cnt == MAXB) begin
              m_rel  = 1'b1;
              m_last = m_owner;
            end
          end
        end else begin
          chk("ack_quiet", bus.ack, 0);
        end
      end
`ifdef TX_ARB_TIMEOUT_EN
      if (|abort) begin
        chk("abort_owner", abort, 1 << m_owner);
        n_abort++;
        abort_cyc = ncyc;
        m_rel     = 1'b1;
        m_last    = m_owner;
      end
`else
      chk("abort_zero", abort, 0);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int unsigned t0;
    int bound;
    bit anyp;
    logic [7:0] exp_d [$];
    logic [2:0] exp_o [$];

    bus.req       = '0;
    bus.last      = '0;
    bus.data      = '0;
    bus.fifo_full = 1'b0;
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Single message from requester 0
    base = wr_log.size();
    push_msg(0, 3, 8'h41, 0);
    step();
    t0 = ncyc;
    repeat (6) step();
    chk("t1_count", wr_log.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_data", wr_log[base+k].d, 8'h41 + 8'(k));
      chk("t1_cycle", wr_log[base+k].cyc, 16'(t0 + 2 + k));
    end
    chk("t1_idle", busy, 0);

    // Two simultaneous requesters
    base = wr_log.size();
    push_msg(1, 2, 8'h11, 0);
    push_msg(2, 2, 8'h21, 0);
    repeat (10) step();
    chk("t2_count", wr_log.size() - base, 4);
    exp_d = '{8'h11, 8'h12, 8'h21, 8'h22};
    exp_o = '{3'd1, 3'd1, 3'd2, 3'd2};
    for (int k = 0; k < 4; k++) begin
      chk("t2_data", wr_log[base+k].d, exp_d[k]);
      chk("t2_owner", wr_log[base+k].own, exp_o[k]);
    end
    chk("t2_gap01", wr_log[base+1].cyc - wr_log[base].cyc, 1);
    chk("t2_gap12", wr_log[base+2].cyc - wr_log[base+1].cyc, 2);
    chk("t2_gap23", wr_log[base+3].cyc - wr_log[base+2].cyc, 1);

    // Burst limit: 20-byte message from 0 with requester 3 waiting
    base = wr_log.size();
    push_msg(0, 20, 8'h80, 0);
    step();
    push_msg(3, 3, 8'h30, 0);
    repeat (40) step();
    exp_d.delete();
    exp_o.delete();
    for (int k = 0; k < 16; k++) begin exp_d.push_back(8'h80 + 8'(k)); exp_o.push_back(3'd0); end
    for (int k = 0; k < 3; k++)  begin exp_d.push_back(8'h30 + 8'(k)); exp_o.push_back(3'd3); end
    for (int k = 16; k < 20; k++) begin exp_d.push_back(8'h80 + 8'(k)); exp_o.push_back(3'd0); end
    chk("t3_count", wr_log.size() - base, 23);
    for (int k = 0; k < 23 && base + k < wr_log.size(); k++) begin
      chk("t3_data", wr_log[base+k].d, exp_d[k]);
      chk("t3_owner", wr_log[base+k].own, exp_o[k]);
    end

    // FIFO full for 10 cycles during the owner's second byte
    base = wr_log.size();
    push_msg(1, 3, 8'h51, 0);
    step();
    step();
    full_force = 1'b1;
    repeat (10) step();
    chk("t4_grant_hold", grant_id, 1);
    chk("t4_busy_hold", busy, 1);
    chk("t4_no_write", wr_log.size() - base, 1);
    full_force = 1'b0;
    repeat (5) step();
    chk("t4_count", wr_log.size() - base, 3);
    chk("t4_resume", wr_log[base+1].cyc - wr_log[base].cyc, 11);
    chk("t4_next", wr_log[base+2].cyc - wr_log[base+1].cyc, 1);

    // Owner 2 stalls after one byte while requester 1 waits
    base = wr_log.size();
    push_msg(2, 3, 8'hA1, 0);
    step();
    step();
    hold[2] = 1'b1;
    push_msg(1, 2, 8'hB1, 0);
    step();
    t0 = ncyc;
    repeat (99) step();
`ifdef TX_ARB_TIMEOUT_EN
    chk("t5_abort_count", n_abort, 1);
    chk("t5_abort_cycle", abort_cyc, t0 + 64);
    chk("t5_regrant", wr_log[base+1].cyc, 16'(abort_cyc + 2));
    exp_d = '{8'hA1, 8'hB1, 8'hB2, 8'hA2, 8'hA3};
    exp_o = '{3'd2, 3'd1, 3'd1, 3'd2, 3'd2};
`else
    chk("t5_stalled", wr_log.size() - base, 1);
    chk("t5_grant_hold", grant_id, 2);
    chk("t5_busy_hold", busy, 1);
    exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
    exp_o = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd1};
`endif
    hold[2] = 1'b0;
    repeat (12) step();
    chk("t5_count", wr_log.size() - base, 5);
    for (int k = 0; k < 5 && base + k < wr_log.size(); k++) begin
      chk("t5_data", wr_log[base+k].d, exp_d[k]);
      chk("t5_owner", wr_log[base+k].own, exp_o[k]);
    end

    // Asynchronous reset while byte 2 of a message is on the write port
    push_msg(0, 3, 8'h41, 0);
    bound = 0;
    while (exp_q[0].size() != 2 && bound < 20) begin
      step();
      bound++;
    end
    chk("t6_reached_byte2", exp_q[0].size(), 2);
    #2;
    chk("t6_wr_before", bus.fifo_wr, 1);
    chk("t6_wdata_before", bus.fifo_wdata, 8'h42);
    reset = 1'b0;
    rst_epoch++;
    #1;
    check_reset_outputs("t6");
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    repeat (3) step();
    check_reset_outputs("t6_held");
    reset = 1'b1;
    base = wr_log.size();
    push_msg(0, 2, 8'hC1, 0);
    step();
    t0 = ncyc;
    repeat (5) step();
    chk("t6_count", wr_log.size() - base, 2);
    chk("t6_first_cycle", wr_log[base].cyc, 16'(t0 + 2));
    chk("t6_first_data", wr_log[base].d, 8'hC1);

    // Randomized traffic with random FIFO back-pressure
    full_pct = 25;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i].size() == 0 && $urandom_range(7) == 0)
          push_msg(i, int'($urandom_range(20, 1)), 8'h00, 1);
      end
      step();
    end
    bound = 0;
    anyp  = 1'b1;
    while (anyp && bound < 3000) begin
      step();
      bound++;
      anyp = 1'b0;
      for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) anyp = 1'b1;
    end
    if (anyp) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles, expected none", bound);
    end
    full_pct = 0;
    repeat (3) step();
    for (int i = 0; i < NREQ; i++) chk("sb_drained", exp_q[i].size(), 0);
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
